// File: rtl/rf_wr_arb.sv
// Register-file write arbiter: A (pipeline) wins, B (multi-cycle) queued and force-served after STARVE_LIMIT.
// Latency A 1 / B >=2 cycles; a_ready drops only in FORCE, b_ready = !full. Busy check: RF_WR_ARB_SCOREBOARD_EN.
module rf_wr_arb #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        wren,
  output logic [4:0]  wraddr,
  output logic [31:0] wrdata,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy1,
  output logic        chk_busy2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic {NORM, FORCE} state_t;

  state_t         state;
  logic [4:0]     q_addr [DEPTH];
  logic [31:0]    q_data [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [7:0]     wait_cnt;

  logic        empty;
  logic        push;
  logic        pop;
  logic        a_fire;
  logic        grant;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

  // Both ready signals depend only on registered state, never on a same-cycle pop.
  assign a_ready  = (state == NORM);
  assign b_ready  = (count < CW'(DEPTH));
  assign empty    = (count == '0);
  assign push     = b_valid && b_ready;
  assign a_fire   = a_valid && (state == NORM);
  assign pop      = !empty && ((state == FORCE) || !a_valid);
  assign grant    = a_fire || pop;
  assign sel_addr = a_fire ? a_addr : q_addr[rd_ptr];
  assign sel_data = a_fire ? a_data : q_data[rd_ptr];

  // Storage needs no reset: occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= b_addr;
      q_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= NORM;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
      wren     <= 1'b0;
      wraddr   <= '0;
      wrdata   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != LIMIT)
        wait_cnt <= wait_cnt + 8'd1;

      // A head served by a normal pop this cycle no longer needs forcing.
      case (state)
        NORM:    if (wait_cnt == LIMIT && !pop) state <= FORCE;
        FORCE:   state <= NORM;
        default: state <= NORM;
      endcase

      // Address 0 is architecturally constant: consume the request, suppress the write.
      if (grant && sel_addr != 5'd0) begin
        wren   <= 1'b1;
        wraddr <= sel_addr;
        wrdata <= sel_data;
      end else begin
        wren   <= 1'b0;
      end
    end
  end

`ifdef RF_WR_ARB_SCOREBOARD_EN
  logic [DEPTH-1:0] q_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld <= '0;
    end else begin
      if (pop)  q_vld[rd_ptr] <= 1'b0;
      if (push) q_vld[wr_ptr] <= 1'b1;
    end
  end

  always_comb begin
    chk_busy1 = 1'b0;
    chk_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && q_addr[i] == chk_addr1) chk_busy1 = 1'b1;
      if (q_vld[i] && q_addr[i] == chk_addr2) chk_busy2 = 1'b1;
    end
    // The entry being enqueued counts as pending so a dependent read can stall this cycle.
    if (push && rst_n && b_addr == chk_addr1) chk_busy1 = 1'b1;
    if (push && rst_n && b_addr == chk_addr2) chk_busy2 = 1'b1;
    if (chk_addr1 == 5'd0) chk_busy1 = 1'b0;
    if (chk_addr2 == 5'd0) chk_busy2 = 1'b0;
  end
`else
  logic unused_chk;
  assign unused_chk = ^{chk_addr1, chk_addr2};
  assign chk_busy1  = 1'b0;
  assign chk_busy2  = 1'b0;
`endif

endmodule
